// File: rtl/command_scheduler.sv
// Command scheduler: queues motor commands in a FIFO and sequences each one
// through executor launch, completion wait and UART acknowledgement.
module command_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    input  logic [7:0]               cmd_lmotor,
    input  logic [7:0]               cmd_rmotor,
    input  logic [7:0]               cmd_dur,
    output logic                     cmd_ready,
    input  logic                     exec_done,
    input  logic                     ack_sent,
    input  logic                     estop,
    output logic                     exec_start,
    output logic [7:0]               exec_lmotor,
    output logic [7:0]               exec_rmotor,
    output logic [7:0]               exec_dur,
    output logic                     exec_abort,
    output logic                     ack_start,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               done_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, RUN, ACK} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [23:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic            w_ack_done;
    logic [23:0]     w_head;

    // Fullness is judged on the current count, so a pop on the same edge
    // never makes room for a push into a full FIFO.
    assign cmd_ready  = (r_count < FULL) & ~estop;
    assign w_push     = cmd_valid & cmd_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign exec_start = (r_state == START);
    assign ack_start  = (r_state == ACK);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_lmotor, cmd_rmotor, cmd_dur};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (estop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // exec_done is only looked at in RUN, so a level left over from the
    // previous command cannot skip START.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_ack_done = 1'b0;
        if (estop) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        w_pop  = 1'b1;
                        w_next = (w_head[7:0] == 8'd0) ? ACK : START;
                    end
                end
                START: w_next = RUN;
                RUN: begin
                    if (exec_done) w_next = ACK;
                end
                ACK: begin
                    if (ack_sent) begin
                        w_next     = IDLE;
                        w_ack_done = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_lmotor <= '0;
            exec_rmotor <= '0;
            exec_dur    <= '0;
            exec_abort  <= 1'b0;
            overflow    <= 1'b0;
            done_count  <= '0;
        end else begin
            exec_abort <= estop & ((r_state == START) | (r_state == RUN));
            if (w_pop) begin
                exec_lmotor <= w_head[23:16];
                exec_rmotor <= w_head[15:8];
                exec_dur    <= w_head[7:0];
            end
            if (cmd_valid & ~cmd_ready & ~estop) overflow <= 1'b1;
            if (w_ack_done) done_count <= done_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_command_scheduler.sv
// Directed, table-driven bench for command_scheduler (DEPTH = 4).
module tb_command_scheduler;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   cmd_valid;
    logic [7:0]             cmd_lmotor, cmd_rmotor, cmd_dur;
    logic                   cmd_ready;
    logic                   exec_done, ack_sent, estop;
    logic                   exec_start, exec_abort, ack_start;
    logic [7:0]             exec_lmotor, exec_rmotor, exec_dur;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [7:0]             done_count;

    always #5 clk = ~clk;

    command_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid),
        .cmd_lmotor(cmd_lmotor), .cmd_rmotor(cmd_rmotor), .cmd_dur(cmd_dur),
        .cmd_ready(cmd_ready), .exec_done(exec_done), .ack_sent(ack_sent),
        .estop(estop), .exec_start(exec_start), .exec_lmotor(exec_lmotor),
        .exec_rmotor(exec_rmotor), .exec_dur(exec_dur), .exec_abort(exec_abort),
        .ack_start(ack_start), .fifo_count(fifo_count), .overflow(overflow),
        .done_count(done_count)
    );

    // Observed outputs packed as {ready,start,ack,abort,count[2:0],ovf,done[7:0],l,r,d}
    logic [39:0] w_act;
    assign w_act = {cmd_ready, exec_start, ack_start, exec_abort, fifo_count,
                    overflow, done_count, exec_lmotor, exec_rmotor, exec_dur};

    typedef struct {
        string       name;
        logic        v;
        logic [23:0] cmd;
        logic        done;
        logic        sent;
        logic        es;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input string nm, input logic v, input logic [23:0] cmd,
                                input logic done, input logic sent, input logic es,
                                input logic ready, input logic start, input logic ack,
                                input logic abort, input logic [2:0] cnt, input logic ovf,
                                input logic [7:0] dcnt, input logic [23:0] ex);
        vec_t t;
        t.name = nm; t.v = v; t.cmd = cmd; t.done = done; t.sent = sent; t.es = es;
        t.exp  = {ready, start, ack, abort, cnt, ovf, dcnt, ex};
        return t;
    endfunction

    task automatic add(input string nm, input logic v, input logic [23:0] cmd,
                       input logic done, input logic sent, input logic es,
                       input logic ready, input logic start, input logic ack,
                       input logic abort, input logic [2:0] cnt, input logic ovf,
                       input logic [7:0] dcnt, input logic [23:0] ex);
        vecs.push_back(mk(nm, v, cmd, done, sent, es, ready, start, ack, abort,
                          cnt, ovf, dcnt, ex));
    endtask

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [23:0] cmd, input logic done,
                         input logic sent, input logic es);
        cmd_valid  = v;
        cmd_lmotor = cmd[23:16];
        cmd_rmotor = cmd[15:8];
        cmd_dur    = cmd[7:0];
        exec_done  = done;
        ack_sent   = sent;
        estop      = es;
    endtask

    task automatic apply(input vec_t t);
        drive(t.v, t.cmd, t.done, t.sent, t.es);
        @(posedge clk);
        #1;
        check(t.name, w_act, t.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] k8;
        int start_seen;

        // Single command
        add("a1_push",   1, 24'h850510, 0,0,0, 1,0,0,0, 3'd1, 0, 8'd0, 24'h000000);
        add("a2_start",  0, 24'h000000, 0,0,0, 1,1,0,0, 3'd0, 0, 8'd0, 24'h850510);
        add("a3_run",    0, 24'h000000, 0,0,0, 1,0,0,0, 3'd0, 0, 8'd0, 24'h850510);
        add("a4_done",   0, 24'h000000, 1,0,0, 1,0,1,0, 3'd0, 0, 8'd0, 24'h850510);
        add("a5_ackhold",0, 24'h000000, 0,0,0, 1,0,1,0, 3'd0, 0, 8'd0, 24'h850510);
        add("a6_sent",   0, 24'h000000, 0,1,0, 1,0,0,0, 3'd0, 0, 8'd1, 24'h850510);
        add("a7_idle",   0, 24'h000000, 0,0,0, 1,0,0,0, 3'd0, 0, 8'd1, 24'h850510);
        // Zero duration skips execution
        add("b1_push",   1, 24'h112200, 0,0,0, 1,0,0,0, 3'd1, 0, 8'd1, 24'h850510);
        add("b2_ack",    0, 24'h000000, 0,0,0, 1,0,1,0, 3'd0, 0, 8'd1, 24'h112200);
        add("b3_sent",   0, 24'h000000, 0,1,0, 1,0,0,0, 3'd0, 0, 8'd2, 24'h112200);
        // Fill and overflow while command A is stalled in RUN
        add("c_pushA",   1, 24'h0A0A0A, 0,0,0, 1,0,0,0, 3'd1, 0, 8'd2, 24'h112200);
        add("c_push1",   1, 24'h010101, 0,0,0, 1,1,0,0, 3'd1, 0, 8'd2, 24'h0A0A0A);
        add("c_push2",   1, 24'h020202, 0,0,0, 1,0,0,0, 3'd2, 0, 8'd2, 24'h0A0A0A);
        add("c_push3",   1, 24'h030303, 0,0,0, 1,0,0,0, 3'd3, 0, 8'd2, 24'h0A0A0A);
        add("c_push4",   1, 24'h040404, 0,0,0, 0,0,0,0, 3'd4, 0, 8'd2, 24'h0A0A0A);
        add("c_push5_ovf",1,24'h050505, 0,0,0, 0,0,0,0, 3'd4, 1, 8'd2, 24'h0A0A0A);
        add("c_doneA",   0, 24'h000000, 1,0,0, 0,0,1,0, 3'd4, 1, 8'd2, 24'h0A0A0A);
        add("c_sentA",   0, 24'h000000, 0,1,0, 0,0,0,0, 3'd4, 1, 8'd3, 24'h0A0A0A);
        for (int k = 1; k <= 4; k++) begin
            k8 = 8'(k);
            // First pop happens with a push offered into the full FIFO: it must be refused
            add($sformatf("c_pop%0d", k), (k == 1), 24'h999999, 0,0,0,
                1,1,0,0, 3'(4-k), 1, 8'(2+k), {k8, k8, k8});
            add($sformatf("c_run%0d", k), 0, 24'h000000, 0,0,0,
                1,0,0,0, 3'(4-k), 1, 8'(2+k), {k8, k8, k8});
            add($sformatf("c_done%0d", k), 0, 24'h000000, 1,0,0,
                1,0,1,0, 3'(4-k), 1, 8'(2+k), {k8, k8, k8});
            add($sformatf("c_sent%0d", k), 0, 24'h000000, 0,1,0,
                1,0,0,0, 3'(4-k), 1, 8'(3+k), {k8, k8, k8});
        end
        // Emergency stop in RUN with two queued
        add("d1_push",   1, 24'h0B0B0B, 0,0,0, 1,0,0,0, 3'd1, 1, 8'd7, 24'h040404);
        add("d2_push",   1, 24'h0C0C0C, 0,0,0, 1,1,0,0, 3'd1, 1, 8'd7, 24'h0B0B0B);
        add("d3_push",   1, 24'h0D0D0D, 0,0,0, 1,0,0,0, 3'd2, 1, 8'd7, 24'h0B0B0B);
        add("d4_estop",  0, 24'h000000, 0,0,1, 0,0,0,1, 3'd0, 1, 8'd7, 24'h0B0B0B);
        add("d5_estop_hold",1,24'h0E0E0E,0,0,1, 0,0,0,0, 3'd0, 1, 8'd7, 24'h0B0B0B);
        add("d6_push",   1, 24'h214365, 0,0,0, 1,0,0,0, 3'd1, 1, 8'd7, 24'h0B0B0B);
        add("d7_start",  0, 24'h000000, 0,0,0, 1,1,0,0, 3'd0, 1, 8'd7, 24'h214365);
        add("d8_run",    0, 24'h000000, 0,0,0, 1,0,0,0, 3'd0, 1, 8'd7, 24'h214365);
        add("d9_done",   0, 24'h000000, 1,0,0, 1,0,1,0, 3'd0, 1, 8'd7, 24'h214365);
        add("d10_sent",  0, 24'h000000, 0,1,0, 1,0,0,0, 3'd0, 1, 8'd8, 24'h214365);
        // Stale exec_done held through START
        add("e1_push",   1, 24'h313233, 1,0,0, 1,0,0,0, 3'd1, 1, 8'd8, 24'h214365);
        add("e2_start",  0, 24'h000000, 1,0,0, 1,1,0,0, 3'd0, 1, 8'd8, 24'h313233);
        add("e3_run",    0, 24'h000000, 1,0,0, 1,0,0,0, 3'd0, 1, 8'd8, 24'h313233);
        add("e4_ack",    0, 24'h000000, 1,0,0, 1,0,1,0, 3'd0, 1, 8'd8, 24'h313233);
        add("e5_sent",   0, 24'h000000, 0,1,0, 1,0,0,0, 3'd0, 1, 8'd9, 24'h313233);
        // Simultaneous push and pop at count DEPTH-1, then estop abort from START
        add("g1_push",   1, 24'h404040, 0,0,0, 1,0,0,0, 3'd1, 1, 8'd9, 24'h313233);
        add("g2_push",   1, 24'h414141, 0,0,0, 1,1,0,0, 3'd1, 1, 8'd9, 24'h404040);
        add("g3_push",   1, 24'h424242, 0,0,0, 1,0,0,0, 3'd2, 1, 8'd9, 24'h404040);
        add("g4_push",   1, 24'h434343, 0,0,0, 1,0,0,0, 3'd3, 1, 8'd9, 24'h404040);
        add("g5_done",   0, 24'h000000, 1,0,0, 1,0,1,0, 3'd3, 1, 8'd9, 24'h404040);
        add("g6_sent",   0, 24'h000000, 0,1,0, 1,0,0,0, 3'd3, 1, 8'd10, 24'h404040);
        add("g7_pushpop",1, 24'h444444, 0,0,0, 1,1,0,0, 3'd3, 1, 8'd10, 24'h414141);
        add("h1_estop",  0, 24'h000000, 0,0,1, 0,0,0,1, 3'd0, 1, 8'd10, 24'h414141);
        add("h2_release",0, 24'h000000, 0,0,0, 1,0,0,0, 3'd0, 1, 8'd10, 24'h414141);

        drive(0, 24'h0, 0, 0, 0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #10;
        check("reset_state", w_act, {1'b1, 39'd0});
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // done_count wrap: 246 zero-duration commands take it from 10 through 255 to 0
        start_seen = 0;
        for (int i = 0; i < 246; i++) begin
            drive(1, {8'(i), 8'h00, 8'h00}, 0, 0, 0);
            @(posedge clk); #1; if (exec_start) start_seen++;
            drive(0, 24'h0, 0, 0, 0);
            @(posedge clk); #1; if (exec_start) start_seen++;
            drive(0, 24'h0, 0, 1, 0);
            @(posedge clk); #1; if (exec_start) start_seen++;
            if (i == 244) check("done_count_255", {32'd0, done_count}, 40'hFF);
        end
        drive(0, 24'h0, 0, 0, 0);
        check("done_count_wrap", {32'd0, done_count}, 40'h00);
        check("zero_dur_no_start", 40'(start_seen), 40'd0);

        // Reset in the middle of an acknowledgement abandons the command
        apply(mk("r1_push",  1, 24'h556677, 0,0,0, 1,0,0,0, 3'd1, 1, 8'd0, 24'h F50000 & 24'h0 | {8'd245, 16'h0000}));
        apply(mk("r2_start", 0, 24'h000000, 0,0,0, 1,1,0,0, 3'd0, 1, 8'd0, 24'h556677));
        apply(mk("r3_run",   0, 24'h000000, 0,0,0, 1,0,0,0, 3'd0, 1, 8'd0, 24'h556677));
        apply(mk("r4_ack",   0, 24'h000000, 1,0,0, 1,0,1,0, 3'd0, 1, 8'd0, 24'h556677));
        drive(0, 24'h0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_ack", w_act, {1'b1, 39'd0});
        @(negedge clk);
        reset_n = 1'b1;
        apply(mk("p1_push",  1, 24'h070809, 0,0,0, 1,0,0,0, 3'd1, 0, 8'd0, 24'h000000));
        apply(mk("p2_start", 0, 24'h000000, 0,0,0, 1,1,0,0, 3'd0, 0, 8'd0, 24'h070809));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
